// File: rtl/tally_uart_serializer.sv
// Tally result serializer: buffers REGISTER_SIZE-bit result blocks in a FIFO
// and streams them to a byte-wide UART transmitter as framed packets of
// HEADER_BYTE, NUM_BLOCKS*4 data bytes (LSB first) and an XOR checksum.
module tally_uart_serializer #(
  parameter int          REGISTER_SIZE = 32,
  parameter int          NUM_BLOCKS    = 64,
  parameter logic [7:0]  HEADER_BYTE   = 8'hA5
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [REGISTER_SIZE-1:0] block_in,
  input  logic                     valid_in,
  input  logic                     uart_busy_in,
  output logic [7:0]               data_byte_out,
  output logic                     trigger_out,
  output logic                     frame_active_out,
  output logic                     done_out,
  output logic                     overflow_out
);

  localparam int FRAME_BYTES = NUM_BLOCKS * 4;
  localparam int CNT_W       = $clog2(FRAME_BYTES) + 1;
  localparam int PTR_W       = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int OCC_W       = $clog2(NUM_BLOCKS + 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SEND      = 2'd1,
    S_WAIT_RISE = 2'd2,
    S_WAIT_IDLE = 2'd3
  } state_t;

  // Phase names the byte currently in flight (or about to be sent in SEND).
  typedef enum logic [1:0] {
    PH_HEADER   = 2'd0,
    PH_DATA     = 2'd1,
    PH_CHECKSUM = 2'd2
  } phase_t;

  state_t state;
  phase_t phase;

  logic [CNT_W-1:0]         byte_cnt;   // data bytes already sent this frame
  logic [7:0]               csum;

  // ---------------- FIFO ----------------
  logic [REGISTER_SIZE-1:0] mem [NUM_BLOCKS];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [OCC_W-1:0]         occ;

  logic                     fifo_empty;
  logic                     fifo_full;
  logic                     push;
  logic                     pop;
  logic                     drop;
  logic [REGISTER_SIZE-1:0] head;
  logic [7:0]               cur_byte;
  logic                     last_data_sent;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_BLOCKS - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_empty     = (occ == '0);
  assign fifo_full      = (occ == OCC_W'(NUM_BLOCKS));
  assign head           = mem[rd_ptr];
  assign cur_byte       = head[{byte_cnt[1:0], 3'b000} +: 8];
  assign last_data_sent = (byte_cnt == CNT_W'(FRAME_BYTES));

  // The head block leaves the FIFO as its fourth byte is launched.
  assign pop  = (state == S_SEND) && (phase == PH_DATA) && (byte_cnt[1:0] == 2'd3);
  // A full FIFO still accepts a write when the head is popped in the same cycle.
  assign push = valid_in && (!fifo_full || pop);
  assign drop = valid_in && fifo_full && !pop;

  // Block storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= block_in;
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      overflow_out <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
      if (drop) overflow_out <= 1'b1;
    end
  end

  // Frame sequencer: launches one byte per SEND, waits out the UART busy
  // window, and stalls in WAIT_IDLE when the next data block is not yet here.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state            <= S_IDLE;
      phase            <= PH_HEADER;
      byte_cnt         <= '0;
      csum             <= '0;
      data_byte_out    <= '0;
      trigger_out      <= 1'b0;
      frame_active_out <= 1'b0;
      done_out         <= 1'b0;
    end else begin
      trigger_out <= 1'b0;
      done_out    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!fifo_empty && !uart_busy_in) begin
            state            <= S_SEND;
            phase            <= PH_HEADER;
            frame_active_out <= 1'b1;
          end
        end
        S_SEND: begin
          trigger_out <= 1'b1;
          state       <= S_WAIT_RISE;
          case (phase)
            PH_HEADER: data_byte_out <= HEADER_BYTE;
            PH_DATA: begin
              data_byte_out <= cur_byte;
              csum          <= csum ^ cur_byte;
              byte_cnt      <= byte_cnt + CNT_W'(1);
            end
            default:   data_byte_out <= csum;
          endcase
        end
        // The UART may not have raised busy yet, so one cycle is ignored.
        S_WAIT_RISE: state <= S_WAIT_IDLE;
        S_WAIT_IDLE: begin
          if (!uart_busy_in) begin
            case (phase)
              PH_CHECKSUM: begin
                state            <= S_IDLE;
                phase            <= PH_HEADER;
                done_out         <= 1'b1;
                frame_active_out <= 1'b0;
                csum             <= '0;
                byte_cnt         <= '0;
              end
              default: begin
                if (last_data_sent) begin
                  phase <= PH_CHECKSUM;
                  state <= S_SEND;
                end else if (!fifo_empty) begin
                  phase <= PH_DATA;
                  state <= S_SEND;
                end
              end
            endcase
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tally_uart_serializer.sv
// Bench for tally_uart_serializer: a queue-based frame model predicts the
// byte stream from the accepted blocks, and a UART model holds busy after
// each trigger.
module tb_tally_uart_serializer;
  localparam int NB = 2;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [31:0] block_in = '0;
  logic        valid_in = 1'b0;
  logic        uart_busy_in = 1'b0;
  logic [7:0]  data_byte_out;
  logic        trigger_out;
  logic        frame_active_out;
  logic        done_out;
  logic        overflow_out;

  always #5 clk_in = ~clk_in;

  tally_uart_serializer #(
    .REGISTER_SIZE(32), .NUM_BLOCKS(NB), .HEADER_BYTE(8'hA5)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .block_in(block_in), .valid_in(valid_in),
    .uart_busy_in(uart_busy_in), .data_byte_out(data_byte_out),
    .trigger_out(trigger_out), .frame_active_out(frame_active_out),
    .done_out(done_out), .overflow_out(overflow_out)
  );

  typedef struct {
    logic [7:0] val;
    bit         blk_end;
    bit         hdr;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       em;
  int         accepted, popped, exp_frames, fb;
  logic [7:0] fx;
  bit         exp_ovf, force_busy, gap_chk;
  int         ntrig, ndone, cyc, last_done_cyc, bcnt;
  int         nchk = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: a block is accepted if fewer than NB blocks are waiting;
  // accepted blocks extend the expected frame stream.
  function automatic void model_block(input logic [31:0] b);
    exp_t e;
    if (accepted - popped >= NB) begin
      exp_ovf = 1'b1;
      return;
    end
    accepted++;
    if (fb == 0) begin
      e.val = 8'hA5; e.hdr = 1'b1; e.blk_end = 1'b0;
      exp_q.push_back(e);
      fx = 8'h00;
    end
    for (int k = 0; k < 4; k++) begin
      e.val = b[8*k +: 8]; e.hdr = 1'b0; e.blk_end = (k == 3);
      fx ^= e.val;
      exp_q.push_back(e);
    end
    fb++;
    if (fb == NB) begin
      e.val = fx; e.hdr = 1'b0; e.blk_end = 1'b0;
      exp_q.push_back(e);
      fb = 0;
      exp_frames++;
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    accepted = 0; popped = 0; exp_frames = 0; fb = 0; fx = 8'h00;
    exp_ovf = 1'b0; ndone = 0;
  endfunction

  // UART model and output monitor: every trigger is checked against the
  // expected stream, then busy is held for 10 cycles.
  initial begin
    ntrig = 0; cyc = 0; last_done_cyc = 0; bcnt = 0;
    forever begin
      @(negedge clk_in);
      cyc++;
      if (bcnt > 0) bcnt--;
      if (trigger_out) begin
        ntrig++;
        if (exp_q.size() == 0) begin
          chk("unexpected_trigger", {24'h0, data_byte_out}, 32'hFFFF_FFFF);
        end else begin
          em = exp_q.pop_front();
          chk("byte", {24'h0, data_byte_out}, {24'h0, em.val});
          if (em.blk_end) popped++;
          if (gap_chk && em.hdr && ndone > 0)
            chk("hdr_gap_le3", 32'(cyc - last_done_cyc <= 3), 32'd1);
        end
        bcnt = 10;
      end
      if (done_out) begin
        ndone++;
        last_done_cyc = cyc;
      end
      uart_busy_in = force_busy || (bcnt > 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk_in);
      valid_in = 1'b0;
    end
  endtask

  task automatic send_raw(input logic [31:0] b);
    @(negedge clk_in);
    block_in = b;
    valid_in = 1'b1;
    model_block(b);
  endtask

  task automatic send(input logic [31:0] b);
    int t = 0;
    while ((accepted - popped >= NB) && t < 3000) begin
      tick(1);
      t++;
    end
    chk("room_timeout", 32'(t < 3000), 32'd1);
    send_raw(b);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    valid_in = 1'b0;
    rst_in = 1'b0;
    model_reset();
    tick(3);
    rst_in = 1'b1;
    tick(1);
  endtask

  task automatic drain();
    int t = 0;
    tick(1);
    while ((exp_q.size() > 0 || frame_active_out) && t < 4000) begin
      tick(1);
      t++;
    end
    chk("drain_timeout", 32'(t < 4000), 32'd1);
    tick(3);
    chk("done_count", ndone, exp_frames);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int n0, n1, t;
    model_reset();
    force_busy = 1'b0; gap_chk = 1'b0;

    // Reset state
    #1 rst_in = 1'b0;
    #2;
    chk("rst_data", {24'h0, data_byte_out}, 32'h0);
    chk("rst_trig", trigger_out, 1'b0);
    chk("rst_active", frame_active_out, 1'b0);
    chk("rst_done", done_out, 1'b0);
    chk("rst_ovf", overflow_out, 1'b0);
    tick(3);
    rst_in = 1'b1;
    n0 = ntrig;
    tick(1);
    chk("no_trig_after_release", ntrig - n0, 0);

    // Test 1: two blocks back to back, one frame
    n0 = ntrig;
    send_raw(32'h04030201);
    send_raw(32'h08070605);
    drain();
    chk("t1_trigs", ntrig - n0, 10);
    chk("t1_ovf", overflow_out, 1'b0);

    // Test 2: three blocks while UART busy -> third dropped
    force_busy = 1'b1;
    do_reset();
    n0 = ntrig;
    send_raw(32'h11111111);
    send_raw(32'h22222222);
    send_raw(32'h33333333);
    tick(20);
    chk("t2_ovf", overflow_out, exp_ovf);
    chk("t2_ovf_model", 32'(exp_ovf), 32'd1);
    chk("t2_no_trig", ntrig - n0, 0);
    force_busy = 1'b0;
    drain();
    chk("t2_trigs", ntrig - n0, 10);
    chk("t2_ovf_sticky", overflow_out, 1'b1);

    // Test 3: second block late -> stall mid-frame
    do_reset();
    n0 = ntrig;
    send_raw(32'h04030201);
    tick(150);
    n1 = ntrig;
    chk("t3_bytes_before_stall", n1 - n0, 5);
    tick(49);
    chk("t3_stall_no_trig", ntrig - n1, 0);
    chk("t3_active", frame_active_out, 1'b1);
    send_raw(32'h08070605);
    drain();

    // Test 4: reset after third data byte
    do_reset();
    n0 = ntrig;
    send_raw(32'hA1B2C3D4);
    send_raw(32'h55667788);
    t = 0;
    while (ntrig - n0 < 4 && t < 500) begin
      tick(1);
      t++;
    end
    chk("t4_wait", 32'(t < 500), 32'd1);
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    chk("t4_data0", {24'h0, data_byte_out}, 32'h0);
    chk("t4_trig0", trigger_out, 1'b0);
    chk("t4_active0", frame_active_out, 1'b0);
    chk("t4_done0", done_out, 1'b0);
    chk("t4_ovf0", overflow_out, 1'b0);
    model_reset();
    n1 = ntrig;
    tick(3);
    rst_in = 1'b1;
    tick(30);
    chk("t4_no_trig_after", ntrig - n1, 0);
    send_raw(32'hDEADBEEF);
    send_raw(32'h0BADF00D);
    drain();

    // Test 5: four blocks -> two frames, quick restart
    do_reset();
    gap_chk = 1'b1;
    send(32'h01020304);
    send(32'h05060708);
    send(32'h090A0B0C);
    send(32'h0D0E0F10);
    drain();
    chk("t5_frames", ndone, 2);
    gap_chk = 1'b0;

    // Test 6: busy stuck high -> no triggers, nothing lost afterwards
    force_busy = 1'b1;
    do_reset();
    n0 = ntrig;
    send_raw(32'hCAFEBABE);
    send_raw(32'h12345678);
    tick(100);
    chk("t6_no_trig", ntrig - n0, 0);
    chk("t6_idle", frame_active_out, 1'b0);
    force_busy = 1'b0;
    drain();

    // Randomized blocks with random gaps
    do_reset();
    for (int i = 0; i < 12; i++) begin
      tick($urandom_range(0, 30));
      send($urandom());
    end
    drain();
    chk("rand_frames", ndone, 6);
    chk("rand_ovf", overflow_out, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
